ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-004 io_imem_req_valid  output  1  fetch request valid.
REQ-005 io_imem_req_ready  input  1  memory accepts request.
REQ-006 io_imem_req_addr  output  64  fetch address (equals current PC).
REQ-007 io_imem_resp_valid  input  1  response valid.
REQ-008 io_imem_resp_data  input  32  fetched instruction word.
REQ-009 io_redirect_valid  input  1  branch/jump redirect from execute.
REQ-010 io_redirect_pc  input  64  redirect target.
REQ-011 io_out_valid  output  1  instruction valid toward decode.
REQ-012 io_out_ready  input  1  decode accepts instruction.
REQ-013 io_out_inst  output  32  instruction to decode (drives decoder io_inst).
REQ-014 io_out_pc  output  64  PC of io_out_inst.
REQ-015 io_halted  output  1  fetch stopped after delivering ebreak.

Function
REQ-016 State machine SHALL have states REQ, WAIT, HOLD, HALT; one outstanding memory request maximum.
REQ-017 REQ: io_imem_req_valid=1 unless io_redirect_valid=1; on req_valid&req_ready -> WAIT.
REQ-018 WAIT: io_imem_req_valid=0; on resp_valid, capture resp_data into 32-bit instruction buffer -> HOLD.
REQ-019 HOLD: io_out_valid = ~io_redirect_valid; io_out_inst = buffer, io_out_pc = PC.
REQ-020 HOLD output fire (out_valid&out_ready): PC <= PC+4 (64-bit wrap-around modulo 2^64), -> REQ; if buffer==32'h00100073 (ebreak) -> HALT instead, PC unchanged.
REQ-021 HALT: no requests, io_out_valid=0, io_halted=1; exits only on redirect.
REQ-022 io_out_valid SHALL be 0 in REQ, WAIT, HALT; outputs held stable in HOLD while out_ready=0.
REQ-023 Redirect in REQ: no request issued that cycle; PC <= redirect_pc; remain REQ.
REQ-024 Redirect in WAIT: PC <= redirect_pc; set drop flag; stay WAIT until resp_valid; response discarded -> REQ; drop flag cleared.
REQ-025 Redirect in WAIT same cycle as resp_valid: response discarded, PC <= redirect_pc -> REQ.
REQ-026 Redirect in HOLD: buffer discarded, no output fire regardless of out_ready, PC <= redirect_pc -> REQ.
REQ-027 Redirect in HALT: PC <= redirect_pc, io_halted cleared -> REQ.
REQ-028 Second redirect while drop flag set: PC overwritten with latest target; only one response dropped.
REQ-029 resp_valid outside WAIT SHALL be ignored.
REQ-030 Minimum latency: request handshake cycle N, response N+k, out_valid from N+k+1; peak throughput one instruction per 3 cycles.

Reset
REQ-031 While reset asserted: state=REQ, PC=RESET_PC, buffer=0, drop flag=0, io_imem_req_valid=0, io_out_valid=0, io_halted=0.
REQ-032 First cycle after reset deassertion: io_imem_req_valid=1, io_imem_req_addr=RESET_PC.
REQ-033 Reset mid-WAIT or mid-HOLD SHALL abandon transaction; no stale instruction delivered.

Verification
REQ-034 Sequential fetch: always-ready memory (1-cycle resp) returning 0x00000013, out_ready=1 -> out_pc 0x80000000, 0x80000004, 0x80000008 at 3-cycle spacing.
REQ-035 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid=1, inst/pc stable, no new request; release -> single fire, PC+4.
REQ-036 Redirect in WAIT to 0x80001000, response 0xdeadbeef arrives 2 cycles later -> never output; next req_addr 0x80001000.
REQ-037 Ebreak: response 0x00100073 at PC 0x80000010 fires -> io_halted=1, req_valid=0 indefinitely; redirect to 0x80000000 -> halted=0, fetch resumes at 0x80000000.
REQ-038 Simultaneous redirect and out_ready in HOLD -> no fire, next req_addr = redirect_pc.
REQ-039 Async reset asserted mid-HOLD (between edges) -> out_valid drops immediately; after release req_addr=0x80000000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry
// instruction buffer, redirect handling and ebreak halt.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [63:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_pc,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_inst,
  output logic [63:0] io_out_pc,
  output logic        io_halted
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        drop_q, drop_d;
  logic        req_valid;
  logic        out_valid;
  logic        halted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    drop_d    = drop_q;
    req_valid = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (io_redirect_valid) begin
          pc_d = io_redirect_pc;
        end else begin
          req_valid = 1'b1;
          if (io_imem_req_ready)
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect cannot cancel the in-flight request, so its
        // response is swallowed instead (exactly one, however many
        // redirects arrive meanwhile).
        if (io_redirect_valid) begin
          pc_d = io_redirect_pc;
          if (io_imem_resp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (io_imem_resp_valid) begin
          if (drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            buf_d   = io_imem_resp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (io_redirect_valid) begin
          pc_d    = io_redirect_pc;
          buf_d   = 32'd0;
          state_d = S_REQ;
        end else begin
          out_valid = 1'b1;
          if (io_out_ready) begin
            if (buf_q == EBREAK) begin
              state_d = S_HALT;
            end else begin
              pc_d    = pc_q + 64'd4;
              state_d = S_REQ;
            end
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (io_redirect_valid) begin
          pc_d    = io_redirect_pc;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State already resets to REQ; the gate keeps req_valid low in reset.
  assign io_imem_req_valid = req_valid & ~reset;
  assign io_imem_req_addr  = pc_q;
  assign io_out_valid      = out_valid & ~reset;
  assign io_out_inst       = buf_q;
  assign io_out_pc         = pc_q;
  assign io_halted         = halted & ~reset;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: sequential fetch, backpressure,
// redirects, ebreak halt, wrap-around and asynchronous reset.
module tb_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready = 1'b0;
  logic [63:0] io_imem_req_addr;
  logic        io_imem_resp_valid = 1'b0;
  logic [31:0] io_imem_resp_data = 32'd0;
  logic        io_redirect_valid = 1'b0;
  logic [63:0] io_redirect_pc = 64'd0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_inst;
  logic [63:0] io_out_pc;
  logic        io_halted;

  int n_cmp = 0;
  int n_bad = 0;

  ifu_fetch dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_inst        (io_out_inst),
    .io_out_pc          (io_out_pc),
    .io_halted          (io_halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [63:0] pc);
    io_imem_req_ready = 1'b1;
    #1;
    chk("req_valid", 64'(io_imem_req_valid), 64'd1);
    chk("req_addr", io_imem_req_addr, pc);
    chk("out_valid_req", 64'(io_out_valid), 64'd0);
    step();
    io_imem_req_ready = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] data);
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = data;
    #1;
    chk("req_valid_wait", 64'(io_imem_req_valid), 64'd0);
    chk("out_valid_wait", 64'(io_out_valid), 64'd0);
    step();
    io_imem_resp_valid = 1'b0;
  endtask

  task automatic do_hold(input logic [31:0] inst,
                         input logic [63:0] pc);
    io_out_ready = 1'b1;
    #1;
    chk("out_valid", 64'(io_out_valid), 64'd1);
    chk("out_inst", 64'(io_out_inst), 64'(inst));
    chk("out_pc", io_out_pc, pc);
    step();
    io_out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_valid", 64'(io_imem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_halted", 64'(io_halted), 64'd0);
    chk("rst_addr", io_imem_req_addr, 64'h8000_0000);
    #3 reset = 1'b0;
    #1;
    chk("post_rst_valid", 64'(io_imem_req_valid), 64'd1);
    step();

    // sequential fetch, three cycles per instruction
    for (int i = 0; i < 3; i++) begin
      do_req(64'h8000_0000 + 64'(4 * i));
      do_resp(32'h0000_0013);
      do_hold(32'h0000_0013, 64'h8000_0000 + 64'(4 * i));
    end

    // backpressure in HOLD
    do_req(64'h8000_000C);
    do_resp(32'h0000_0113);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_valid", 64'(io_out_valid), 64'd1);
      chk("bp_inst", 64'(io_out_inst), 64'h0000_0113);
      chk("bp_pc", io_out_pc, 64'h8000_000C);
      chk("bp_req_valid", 64'(io_imem_req_valid), 64'd0);
      step();
    end
    do_hold(32'h0000_0113, 64'h8000_000C);

    // ebreak halts; stray responses ignored
    do_req(64'h8000_0010);
    do_resp(32'h0010_0073);
    do_hold(32'h0010_0073, 64'h8000_0010);
    for (int i = 0; i < 4; i++) begin
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = 32'h0000_0013;
      #1;
      chk("halt_halted", 64'(io_halted), 64'd1);
      chk("halt_req_valid", 64'(io_imem_req_valid), 64'd0);
      chk("halt_out_valid", 64'(io_out_valid), 64'd0);
      step();
    end
    io_imem_resp_valid = 1'b0;
    io_redirect_valid  = 1'b1;
    io_redirect_pc     = 64'h8000_0000;
    step();
    io_redirect_valid  = 1'b0;
    #1;
    chk("unhalt", 64'(io_halted), 64'd0);
    do_req(64'h8000_0000);

    // redirect in WAIT, response arrives later and is dropped
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'h8000_1000;
    step();
    io_redirect_valid = 1'b0;
    step();
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'hdead_beef;
    step();
    io_imem_resp_valid = 1'b0;
    #1;
    chk("drop_out_valid", 64'(io_out_valid), 64'd0);
    do_req(64'h8000_1000);
    do_resp(32'h0000_0013);

    // redirect and out_ready together in HOLD
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'h8000_2000;
    io_out_ready      = 1'b1;
    #1;
    chk("hold_redir_out_valid", 64'(io_out_valid), 64'd0);
    step();
    io_redirect_valid = 1'b0;
    io_out_ready      = 1'b0;

    // redirect in REQ suppresses the request
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'h8000_3000;
    io_imem_req_ready = 1'b1;
    #1;
    chk("req_redir_valid", 64'(io_imem_req_valid), 64'd0);
    step();
    io_redirect_valid = 1'b0;
    do_req(64'h8000_3000);

    // redirect coincident with response
    io_redirect_valid  = 1'b1;
    io_redirect_pc     = 64'h8000_4000;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h1111_1111;
    step();
    io_redirect_valid  = 1'b0;
    io_imem_resp_valid = 1'b0;
    do_req(64'h8000_4000);

    // two redirects in WAIT drop exactly one response
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'h8000_5000;
    step();
    io_redirect_pc    = 64'h8000_6000;
    step();
    io_redirect_valid  = 1'b0;
    io_imem_resp_valid = 1'b1;
    io_imem_resp_data  = 32'h0000_0bad;
    step();
    io_imem_resp_valid = 1'b0;
    do_req(64'h8000_6000);
    do_resp(32'h0000_0093);
    do_hold(32'h0000_0093, 64'h8000_6000);

    // PC wraps modulo 2^64
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    io_redirect_valid = 1'b0;
    do_req(64'hFFFF_FFFF_FFFF_FFFC);
    do_resp(32'h0000_0013);
    do_hold(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC);
    do_req(64'h0);

    // asynchronous reset between edges while in HOLD
    do_resp(32'h0000_0213);
    #1;
    chk("pre_rst_out_valid", 64'(io_out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(io_out_valid), 64'd0);
    chk("arst_req_valid", 64'(io_imem_req_valid), 64'd0);
    chk("arst_addr", io_imem_req_addr, 64'h8000_0000);
    chk("arst_inst", 64'(io_out_inst), 64'd0);
    @(posedge clock);
    #3 reset = 1'b0;
    step();
    do_req(64'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
